fetch_queue: RTL and testbench

Parametrised instruction-fetch stage with a decoupling queue between PC generation and DECODE. Each enabled cycle it reads one word from an internal instruction RAM at the current PC, pushes the {pc, instr} pair into a DEPTH-entry FIFO and advances the PC. DECODE drains the FIFO through a valid/stall handshake. A MEMORY-stage redirect flushes the queue and restarts fetch at the target. It replaces the single-register fetch stage, so fetch can run ahead of short DECODE stalls.

---
 rtl/pipe_pkg.sv | 16 +
 rtl/sync_fifo.sv | 46 ++++
 rtl/fetch_queue.sv | 74 +++++++
 tb/tb_fetch_queue.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline types: the fetch-queue entry layout and pointer-width helper.
package pipe_pkg;

  localparam int WORD_W = 32;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] instr;
  } fetch_entry_t;

  // A single-entry FIFO still needs one pointer bit so the vectors stay legal.
  function automatic int FETCH_PTR_W(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head reads as zero while empty.
module sync_fifo
  import pipe_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int PTR_W = FETCH_PTR_W(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !reset && !flush) mem[wr_ptr] <= din;
  end

  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch stage: PC register, instruction RAM and a decoupling
// queue toward DECODE, flushed by a MEMORY-stage redirect.
module fetch_queue
  import pipe_pkg::*;
#(
  parameter int                IMEM_POWER = 18,
  parameter int                DEPTH      = 4,
  parameter logic [WORD_W-1:0] RESET_PC   = '0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       stallD,
  input  logic                       PCSrcM,
  input  logic [WORD_W-1:0]          pcM,
  output logic [WORD_W-1:0]          pcD,
  output logic [WORD_W-1:0]          instrD,
  output logic                       validD,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WORD_W-1:0] imem [2**IMEM_POWER];
  logic [WORD_W-1:0] pc;
  logic [WORD_W-1:0] pc_next;

  logic         push;
  logic         pop;
  logic         redirect;
  logic [CNT_W-1:0] count;
  fetch_entry_t new_entry;
  fetch_entry_t head_entry;

  // Redirect outranks both the stall and the full/empty state.
  assign redirect = en & PCSrcM;
  assign pop      = en & validD & ~stallD & ~PCSrcM;
  assign push     = en & ~PCSrcM & ((count < FULL_CNT) | pop);

  assign new_entry.pc    = pc;
  assign new_entry.instr = imem[pc[IMEM_POWER+1:2]];

  sync_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(DEPTH)
  ) fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .flush(redirect),
    .din  (new_entry),
    .head (head_entry),
    .count(count)
  );

  always_comb begin
    pc_next = pc;
    if (redirect)  pc_next = pcM;
    else if (push) pc_next = pc + WORD_W'(4);
  end

  always_ff @(posedge clk) begin
    if (reset) pc <= RESET_PC;
    else        pc <= pc_next;
  end

  assign validD = (count != '0);
  assign level  = count;
  assign pcD    = head_entry.pc;
  assign instrD = head_entry.instr;

endmodule

// File: tb/tb_fetch_queue.sv
// Randomised and directed bench for fetch_queue against a queue-based model.
module tb_fetch_queue;
  import pipe_pkg::*;

  localparam int DEPTH      = 4;
  localparam int IMEM_POWER = 18;
  localparam int RAM_WORDS  = 2**IMEM_POWER;

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        stallD;
  logic        PCSrcM;
  logic [31:0] pcM;
  logic [31:0] pcD;
  logic [31:0] instrD;
  logic        validD;
  logic [2:0]  level;

  int checks = 0;
  int errors = 0;

  logic [31:0]  ram_model [RAM_WORDS];
  fetch_entry_t model_q[$];
  logic [31:0]  model_pc;

  always #5 clk = ~clk;

  fetch_queue #(
    .IMEM_POWER(IMEM_POWER),
    .DEPTH(DEPTH),
    .RESET_PC(32'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .en    (en),
    .stallD(stallD),
    .PCSrcM(PCSrcM),
    .pcM   (pcM),
    .pcD   (pcD),
    .instrD(instrD),
    .validD(validD),
    .level (level)
  );

  function automatic logic [31:0] ram_read(input logic [31:0] addr);
    return ram_model[addr[IMEM_POWER+1:2]];
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic checkAll();
    fetch_entry_t head;
    head = (model_q.size() != 0) ? model_q[0] : '0;
    checkOutput("level",  32'(level),  32'(model_q.size()));
    checkOutput("validD", 32'(validD), 32'(model_q.size() != 0));
    checkOutput("pcD",    pcD,         head.pc);
    checkOutput("instrD", instrD,      head.instr);
    checkOutput("pc",     dut.pc,      model_pc);
  endtask

  // Drives one cycle from the falling edge, advances the model, then checks.
  task automatic applyStimulus(input logic r, input logic e, input logic s,
                               input logic p, input logic [31:0] target);
    fetch_entry_t ent;
    bit do_pop;
    bit do_push;
    reset  = r;
    en     = e;
    stallD = s;
    PCSrcM = p;
    pcM    = target;
    if (r) begin
      model_q.delete();
      model_pc = 32'h0;
    end else if (e) begin
      if (p) begin
        model_q.delete();
        model_pc = target;
      end else begin
        do_pop  = (model_q.size() > 0) && !s;
        do_push = (model_q.size() < DEPTH) || do_pop;
        if (do_pop) void'(model_q.pop_front());
        if (do_push) begin
          ent.pc    = model_pc;
          ent.instr = ram_read(model_pc);
          model_q.push_back(ent);
          model_pc = model_pc + 32'd4;
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    checkAll();
  endtask

  initial begin
    logic [31:0] exp_instr [4];
    int          exp_level [6];
    logic [31:0] saved_pc;
    int          saved_level;

    exp_instr = '{32'h13, 32'h93, 32'h113, 32'h193};
    exp_level = '{1, 2, 3, 4, 4, 4};

    for (int i = 0; i < RAM_WORDS; i++) ram_model[i] = $urandom;
    for (int i = 0; i < 4; i++) ram_model[i] = exp_instr[i];
    for (int i = 0; i < RAM_WORDS; i++) dut.imem[i] = ram_model[i];

    reset = 1'b1; en = 1'b0; stallD = 1'b0; PCSrcM = 1'b0; pcM = '0;
    model_q.delete();
    model_pc = 32'h0;
    @(negedge clk);

    // Reset, then free-run
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    checkOutput("reset_level", 32'(level), 32'd0);
    checkOutput("reset_pcD", pcD, 32'd0);
    for (int k = 0; k < 4; k++) begin
      applyStimulus(0, 1, 0, 0, 0);
      checkOutput("run_pcD", pcD, 32'(k * 4));
      checkOutput("run_instrD", instrD, exp_instr[k]);
      checkOutput("run_level", 32'(level), 32'd1);
    end

    // Stall fills the queue, then drain with push-on-pop at full
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 1, 1, 0, 0);
      checkOutput("stall_level", 32'(level), 32'(exp_level[k]));
    end
    checkOutput("stall_pc", dut.pc, 32'd16);
    checkOutput("stall_head", pcD, 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("drain_level", 32'(level), 32'd4);
    checkOutput("drain_pcD", pcD, 32'd4);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("drain_pcD2", pcD, 32'd8);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("drain_pcD3", pcD, 32'd12);

    // Redirect at level 3
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++) applyStimulus(0, 1, 1, 0, 0);
    checkOutput("pre_redir_level", 32'(level), 32'd3);
    applyStimulus(0, 1, 0, 1, 32'h100);
    checkOutput("redir_level", 32'(level), 32'd0);
    checkOutput("redir_valid", 32'(validD), 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("redir_pcD", pcD, 32'h100);
    checkOutput("redir_instrD", instrD, ram_model[32'h40]);

    // Redirect with stall on a full queue
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(0, 1, 1, 1, 32'h200);
    checkOutput("full_redir_level", 32'(level), 32'd0);
    checkOutput("full_redir_pc", dut.pc, 32'h200);

    // Enable low freezes everything, including a redirect
    for (int k = 0; k < 2; k++) applyStimulus(0, 1, 1, 0, 0);
    saved_pc    = model_pc;
    saved_level = model_q.size();
    applyStimulus(0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 32'h300);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("freeze_pc", dut.pc, saved_pc);
    checkOutput("freeze_level", 32'(level), 32'(saved_level));

    // Reset while level = 2
    applyStimulus(1, 1, 0, 0, 0);
    for (int k = 0; k < 2; k++) applyStimulus(0, 1, 1, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("mid_reset_level", 32'(level), 32'd0);
    checkOutput("mid_reset_instrD", instrD, 32'd0);
    applyStimulus(0, 1, 0, 0, 0);
    checkOutput("restart_pcD", pcD, 32'h0);
    checkOutput("restart_instrD", instrD, 32'h13);

    // Randomised traffic
    for (int k = 0; k < 1500; k++) begin
      applyStimulus($urandom_range(0, 99) == 0,
                    $urandom_range(0, 9) != 0,
                    $urandom_range(0, 9) < 4,
                    $urandom_range(0, 19) == 0,
                    32'($urandom_range(0, 4095)) << 2);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
